nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Upstream sequencer for the 4-bit ripple-carry adder slice. Adds two
//  WIDTH-bit operands one nibble per clock through a single 4-bit adder
//  slice, carrying between nibbles in a register. Valid/ready handshake on
//  both sides; sits between an operand source and a result consumer.
// PARAMETERS
//  NIBBLES  4  number of 4-bit nibbles per operand (>=1); WIDTH = 4*NIBBLES
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand source has a,b,ci valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_ci      in   1      carry-in to nibble 0
//  out_valid  out  1      out_sum/out_co valid (DONE only)
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  (in_a+in_b+in_ci) mod 2^WIDTH
//  out_co     out  1      carry-out of top nibble
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, cnt=0, carry=0, out_sum=0,
//    out_co=0, out_valid=0, busy=0; in_ready=1 in first cycle after reset.
//    Reset has priority over every other event, incl. mid-RUN/DONE: the
//    operation in flight is dropped and no result is produced.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&in_ready at edge: latch in_a,in_b into
//      op regs, carry<=in_ci, cnt<=0, -> RUN. Otherwise stay.
//    RUN: each edge: slice computes op_a[4cnt+:4]+op_b[4cnt+:4]+carry;
//      sum nibble written to out_sum[4cnt+:4], carry<=slice c0, cnt<=cnt+1.
//      At the edge processing cnt==NIBBLES-1: out_co<=slice c0, -> DONE.
//    DONE: out_valid=1; out_sum/out_co held stable. out_valid&out_ready at
//      edge -> IDLE. out_ready low holds DONE indefinitely.
//  - Latency: out_valid high exactly NIBBLES cycles after accepting edge.
//    Minimum issue interval NIBBLES+2 cycles (no accept in DONE cycle).
//  - in_valid/in_a/in_b/in_ci ignored outside IDLE; in_ready=0 there.
//  - out_sum bits not yet written in RUN are don't-care; only DONE values
//    are architecturally visible. out_sum/out_co keep last result in IDLE.
//  - Carry chains across all nibbles (ripple per cycle); wrap mod 2^WIDTH.
//  - cnt width = clog2(NIBBLES) (min 1); NIBBLES=1 -> RUN lasts 1 cycle.
//  - Outputs in_ready, out_valid, busy decoded from registered state only.
// STRUCTURE
//  - nsa_defs.vh: state encoding localparams S_IDLE=2'd0, S_RUN=2'd1,
//    S_DONE=2'd2; illegal encoding 2'd3 -> IDLE.
//  - One sub-module: nib_add4 (4-bit combinational ripple slice,
//    ports a[3:0], b[3:0], ci, s[3:0], c0) instantiated once.
//  - Top holds FSM, cnt, carry, op_a/op_b, result regs, nibble muxing.
// TESTING  (NIBBLES=4; out_ready=1 unless stated)
//  1 0x0001+0x0001 ci=0 -> out_valid 4 cycles after accept, 0x0002 co=0
//  2 0xFFFF+0x0001 ci=0 -> 0x0000 co=1 (carry through all 4 nibbles)
//  3 0x1234+0x4321 ci=1 -> 0x5556 co=0; 0x8000+0x8000 ci=1 -> 0x0001 co=1
//  4 out_ready low 3 cycles in DONE -> out_valid held, out_sum stable,
//    in_ready=0; new in_valid pulses during RUN/DONE produce no effect
//  5 rst=1 at 2nd RUN edge -> next cycle out_valid=0, busy=0, in_ready=1,
//    out_sum=0; following op 0x00FF+0x0F01 -> 0x1000 co=0
//  6 random a,b,ci x1000 vs reference model incl. random out_ready stalls

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial adder.
// State encoding; the unused code 2'd3 recovers to IDLE.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } nsa_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_nib_add4.sv
// 4-bit combinational ripple-carry slice.
// One full-adder per bit, carry rippling from bit 0 upward.
module nib_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c0
);

    logic w_c1;
    logic w_c2;
    logic w_c3;

    assign s[0] = a[0] ^ b[0] ^ ci;
    assign w_c1 = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ w_c1;
    assign w_c2 = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));
    assign s[2] = a[2] ^ b[2] ^ w_c2;
    assign w_c3 = (a[2] & b[2]) | (w_c2 & (a[2] ^ b[2]));
    assign s[3] = a[3] ^ b[3] ^ w_c3;
    assign c0   = (a[3] & b[3]) | (w_c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two 4*NIBBLES-bit operands one nibble per clock
// through a single 4-bit slice, with valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int WIDTH  = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
);

    localparam int CW = cnt_width(NIBBLES);

    nsa_state_t       r_state;
    nsa_state_t       w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s;
    logic             w_c0;
    logic             w_last;

    assign w_last = (r_cnt == CW'(NIBBLES - 1));

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_nib = r_op_a[4*k +: 4];
                w_b_nib = r_op_b[4*k +: 4];
            end
        end
    end

    nib_add4 u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .ci (r_carry),
        .s  (w_s),
        .c0 (w_c0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = in_valid ? S_RUN : S_IDLE;
            S_RUN:  w_next = w_last ? S_DONE : S_RUN;
            S_DONE: w_next = out_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_op_a  <= in_a;
                r_op_b  <= in_b;
                r_carry <= in_ci;
                r_cnt   <= '0;
            end
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < NIBBLES; k++) begin
                if (r_cnt == CW'(k)) begin
                    r_sum[4*k +: 4] <= w_s;
                end
            end
            r_carry <= w_c0;
            if (w_last) begin
                r_co  <= w_c0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_sum   = r_sum;
    assign out_co    = r_co;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder,
// compared against plain integer addition.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs(input bit en);
        in_valid = en ? 1'($urandom_range(0, 1)) : 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_ci    = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic         ci,
                          input int           stall,
                          input bit           junk);
        logic [W:0] exp;
        logic [W:0] held;
        int         n;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        tick();
        n = 0;
        while (!out_valid && n < 20) begin
            check("run_ready", {31'd0, in_ready}, 32'd0);
            check("run_busy", {31'd0, busy}, 32'd1);
            junk_inputs(junk);
            tick();
            n++;
        end
        check("latency", n, NIB);
        check("sum", {16'd0, out_sum}, {16'd0, exp[W-1:0]});
        check("co", {31'd0, out_co}, {31'd0, exp[W]});
        held = {out_co, out_sum};
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                junk_inputs(junk);
                tick();
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_ready", {31'd0, in_ready}, 32'd0);
                check("stall_hold", {15'd0, out_co, out_sum},
                      {15'd0, exp});
            end
        end
        out_ready = 1'b1;
        junk_inputs(junk);
        tick();
        junk_inputs(1'b0);
        check("exit_valid", {31'd0, out_valid}, 32'd0);
        check("exit_ready", {31'd0, in_ready}, 32'd1);
        check("idle_keep", {15'd0, out_co, out_sum}, {15'd0, held});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {15'd0, out_co, out_sum}, 32'd0);

        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b1, 0, 1'b0);
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 3, 1'b1);

        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_ci    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_ready", {31'd0, in_ready}, 32'd1);
        check("mid_sum", {15'd0, out_co, out_sum}, 32'd0);
        tick();
        tick();
        tick();
        check("mid_drop", {31'd0, out_valid}, 32'd0);
        run_op(16'h00FF, 16'h0F01, 1'b0, 0, 1'b0);

        for (int t = 0; t < 1000; t++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   s, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
